// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// mem_ready wait handshake, illegal-opcode trap and retired-instruction count.
// Optional macro MEM_TIMEOUT_EN adds a bounded memory wait that ends in a
// sticky ERROR state (mem_timeout=1) cleared only by reset.
module multicycle_control #(
  parameter int OPCODE_W    = 6,
  parameter int ALUOP_W     = 4,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_source,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [3:0]          state_o,
  output logic                illegal_op,
  output logic                instr_done,
  output logic [CNT_W-1:0]    instr_count,
  output logic                mem_timeout
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC = 4'd3,
    S_MEM    = 4'd4, S_WB    = 4'd5, S_BRANCH = 4'd6, S_JUMP = 4'd7,
    S_TRAP   = 4'd8, S_ERROR = 4'd9
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000, OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100, OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BLEZ = 6'b000110, OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110, OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011, OP_SW   = 6'b101011;

  state_t     state, nxt;
  logic [5:0] op_q;
  logic       hi_zero;
  logic       wait_expired;
  logic [3:0] aop4;

  // Any nonzero bit above the 6 decoded bits makes the opcode illegal.
  assign hi_zero = ((opcode >> 6) == '0);
  assign state_o = state;
  assign alu_op  = ALUOP_W'(aop4);

`ifdef MEM_TIMEOUT_EN
  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  logic [WCW-1:0] wait_cnt;

  // The wait that would become the MEM_TIMEOUT-th one diverts to ERROR.
  assign wait_expired = (wait_cnt == WCW'(MEM_TIMEOUT - 1));
  assign mem_timeout  = (state == S_ERROR);

  // Count consecutive mem_ready=0 cycles; cleared whenever the state changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  wait_cnt <= '0;
    else if (nxt != state)      wait_cnt <= '0;
    else if ((state == S_FETCH || state == S_MEM) && !mem_ready)
                                wait_cnt <= wait_cnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^MEM_TIMEOUT;
  assign wait_expired   = 1'b0;
  assign mem_timeout    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RESET;
    else       state <= nxt;
  end

  // Opcode is captured in DECODE; later states decode from the latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 op_q <= '0;
    else if (state == S_DECODE) op_q <= opcode[5:0];
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           instr_count <= '0;
    else if (instr_done) instr_count <= instr_count + 1'b1;
  end

  // Next-state and datapath control decode.
  always_comb begin
    nxt           = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    aop4          = 4'b0000;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;
    case (state)
      S_RESET: nxt = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)         nxt = S_DECODE;
        else if (wait_expired) nxt = S_ERROR;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (!hi_zero) nxt = S_TRAP;
        else begin
          case (opcode[5:0])
            OP_J:                             nxt = S_JUMP;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: nxt = S_BRANCH;
            OP_R, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_LW, OP_SW:                     nxt = S_EXEC;
            default:                          nxt = S_TRAP;
          endcase
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = (op_q == OP_R) ? 2'b00 : 2'b10;
        case (op_q)
          OP_R:    aop4 = 4'b1000;
          OP_ANDI: aop4 = 4'b0001;
          OP_ORI:  aop4 = 4'b0010;
          OP_XORI: aop4 = 4'b0011;
          OP_LUI:  aop4 = 4'b1010;
          OP_SLTI: aop4 = 4'b1011;
          default: aop4 = 4'b0000;
        endcase
        nxt = (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
        if (mem_ready) begin
          instr_done = (op_q == OP_SW);
          nxt        = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else if (wait_expired) begin
          nxt = S_ERROR;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_q == OP_R);
        mem_to_reg = (op_q == OP_LW);
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        case (op_q)
          OP_BEQ:  aop4 = 4'b0001;
          OP_BNE:  aop4 = 4'b0110;
          OP_BLEZ: aop4 = 4'b0111;
          default: aop4 = 4'b1001;
        endcase
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_TRAP: begin
        illegal_op = 1'b1;
        nxt        = S_FETCH;
      end
      S_ERROR: nxt = S_ERROR;
      default: nxt = S_RESET;
    endcase
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle opcode decoder in the MIPS datapath.
- A state machine sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Memory access uses a mem_ready wait handshake; illegal opcodes trap.
- Retired instructions are counted; the ALU-op field is width-parametrised.

Parameters:
- OPCODE_W, 6: opcode width. Only the low 6 bits are decoded; upper bits must be 0, otherwise the opcode is illegal.
- ALUOP_W, 4: alu_op width (≥4). Codes are zero-extended.
- CNT_W, 32: width of the retired-instruction counter.
- MEM_TIMEOUT, 15: maximum number of mem_ready wait cycles. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  OPCODE_W  instruction opcode from the IR; sampled in DECODE
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls
- alu_src_b  out  2  00 = reg B, 01 = +4, 10 = sign-extended immediate, 11 = shifted immediate
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- alu_op  out  ALUOP_W  ALU operation
- state_o  out  4  current state, for debug
- illegal_op  out  1  one-cycle pulse on trap
- instr_done  out  1  one-cycle pulse when an instruction retires
- instr_count  out  CNT_W  number of retired instructions
- mem_timeout  out  1  sticky error flag (MEM_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is asynchronous and active-high.
  - Reset forces state=RESET (0) and instr_count=0, and drives every output to 0 immediately.
  - A reset mid-instruction abandons the instruction with no further writes.
- State encoding: RESET 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, BRANCH 6, JUMP 7, TRAP 8, ERROR 9. Only the state and the latched opcode are registered; outputs decode combinationally from state, latched opcode and mem_ready.
- RESET: all outputs 0. Next state FETCH, unconditionally.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=0000, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Latches opcode. Drives alu_src_a=0, alu_src_b=11, alu_op=0000.
  - Next state by opcode:
    - 000010 → JUMP
    - 000100–000111 → BRANCH
    - 000000, 001000, 001010, 001100–001111, 100011, 101011 → EXEC
    - anything else → TRAP
- EXEC:
  - alu_src_a=1.
  - alu_src_b=00 for R-type, 10 otherwise.
  - alu_op: R 1000, addi/lw/sw 0000, andi 0001, ori 0010, xori 0011, lui 1010, slti 1011.
  - Next state: lw/sw → MEM, otherwise → WB.
- MEM:
  - i_or_d=1. mem_read=1 for lw, mem_write=1 for sw; the strobe is held until mem_ready.
  - On mem_ready: lw → WB; sw retires → FETCH.
- WB:
  - reg_write=1 for exactly one cycle.
  - reg_dst=1 for R-type. mem_to_reg=1 for lw.
  - Retires → FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, pc_write_cond=1, pc_source=01.
  - alu_op: beq 0001, bne 0110, blez 0111, bgtz 1001.
  - Retires → FETCH.
- JUMP: pc_write=1, pc_source=10. Retires → FETCH.
- TRAP: illegal_op=1, no write strobes, not counted as retired. Next state FETCH.
- Retire: instr_done=1 in the retiring cycle; instr_count increments on the following edge and wraps to 0 after 2^CNT_W−1.
- Latency with mem_ready held at 1: R/I-type 4 cycles, lw 5, sw 4, branch 3, jump 3, trap 3.
- Invariants:
  - mem_read and mem_write are never both 1.
  - pc_write and pc_write_cond are never both 1.
  - Any state encoding not listed above → RESET on the next edge.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- When defined:
  - A wait counter clears on entry to FETCH or MEM and counts cycles with mem_ready=0.
  - If it reaches MEM_TIMEOUT, the FSM goes to ERROR.
  - In ERROR, all strobes are 0 and mem_timeout=1. The FSM stays in ERROR until reset.
- When undefined: no wait counter, waits are unbounded, mem_timeout is tied to 0, and ERROR is unreachable.

Test Plan:
- Reset release, mem_ready=1, opcode=000000 → states 0,1,2,3,5,1. alu_op=1000 in EXEC. reg_write=reg_dst=1 in WB. instr_count=1.
- lw (100011) with mem_ready low for 3 cycles in MEM → mem_read held 4 cycles with i_or_d=1, then WB with mem_to_reg=1. Total 8 cycles.
- sw (101011) → mem_write=1 in MEM, goes to FETCH without WB, reg_write never asserted, instr_done pulses once.
- beq (000100) → BRANCH with pc_write_cond=1, pc_source=01, alu_op=0001. j (000010) → pc_write=1, pc_source=10.
- opcode 111111 → TRAP, illegal_op pulses 1 cycle, instr_count unchanged, next state FETCH. Reset asserted mid-MEM → all outputs 0 immediately.
- MEM_TIMEOUT_EN, MEM_TIMEOUT=15, mem_ready stuck at 0 in FETCH → ERROR after 15 wait cycles, mem_timeout=1 sticky, cleared only by reset.
